// File: rtl/alu_sweep_ctrl.sv
// Sweeps all 16 {c_in, oper} combinations through an external 8-bit ALU for one latched
// operand pair, streams each settled result and folds it into a 16-bit signature.
// Define ALU_SWEEP_CHECK_EN to add an end-of-sweep signature compare (exp_sig / mismatch).
module alu_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_c_in,
  output logic [2:0]  alu_oper,
  input  logic [7:0]  alu_sum,
  input  logic        alu_c_out,
  output logic        busy,
  output logic        res_valid,
  output logic [3:0]  res_idx,
  output logic [7:0]  res_sum,
  output logic        res_c_out,
  output logic        done,
`ifdef ALU_SWEEP_CHECK_EN
  input  logic [15:0] exp_sig,
  output logic        mismatch,
`endif
  output logic [15:0] signature
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [3:0]  idx_reg, idx_next;
  logic [7:0]  alu_a_reg, alu_a_next;
  logic [7:0]  alu_b_reg, alu_b_next;
  logic        busy_reg, busy_next;
  logic        res_valid_reg, res_valid_next;
  logic [3:0]  res_idx_reg, res_idx_next;
  logic [7:0]  res_sum_reg, res_sum_next;
  logic        res_c_out_reg, res_c_out_next;
  logic        done_reg, done_next;
  logic [15:0] sig_reg, sig_next;
`ifdef ALU_SWEEP_CHECK_EN
  logic        mismatch_reg, mismatch_next;
`endif

  // Signature step: rotate left by one, then fold in the 9-bit {c_out, sum} sample.
  logic [8:0]  sample_word;
  logic [15:0] sig_fold;

  assign sample_word = {alu_c_out, alu_sum};

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_fold
      if (gi < 9) begin : g_mix
        assign sig_fold[gi] = sig_reg[(gi + 15) % 16] ^ sample_word[gi];
      end else begin : g_rot
        assign sig_fold[gi] = sig_reg[gi - 1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      busy_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      res_idx_reg   <= '0;
      res_sum_reg   <= '0;
      res_c_out_reg <= 1'b0;
      done_reg      <= 1'b0;
      sig_reg       <= '0;
`ifdef ALU_SWEEP_CHECK_EN
      mismatch_reg  <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      busy_reg      <= busy_next;
      res_valid_reg <= res_valid_next;
      res_idx_reg   <= res_idx_next;
      res_sum_reg   <= res_sum_next;
      res_c_out_reg <= res_c_out_next;
      done_reg      <= done_next;
      sig_reg       <= sig_next;
`ifdef ALU_SWEEP_CHECK_EN
      mismatch_reg  <= mismatch_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    alu_a_next     = alu_a_reg;
    alu_b_next     = alu_b_reg;
    busy_next      = busy_reg;
    res_valid_next = 1'b0;
    res_idx_next   = res_idx_reg;
    res_sum_next   = res_sum_reg;
    res_c_out_next = res_c_out_reg;
    done_next      = 1'b0;
    sig_next       = sig_reg;
`ifdef ALU_SWEEP_CHECK_EN
    mismatch_next  = mismatch_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start) begin
          alu_a_next = a_in;
          alu_b_next = b_in;
          idx_next   = 4'h0;
          sig_next   = '0;
          cnt_next   = SETTLE_LOAD;
          busy_next  = 1'b1;
          state_next = WAIT;
`ifdef ALU_SWEEP_CHECK_EN
          mismatch_next = 1'b0;
`endif
        end
      end

      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      SAMPLE: begin
        res_valid_next = 1'b1;
        res_idx_next   = idx_reg;
        res_sum_next   = alu_sum;
        res_c_out_next = alu_c_out;
        sig_next       = sig_fold;
        if (idx_reg == 4'hF) begin
          done_next  = 1'b1;
          state_next = DONE;
`ifdef ALU_SWEEP_CHECK_EN
          mismatch_next = (sig_fold != exp_sig);
`endif
        end else begin
          idx_next   = idx_reg + 4'd1;
          cnt_next   = SETTLE_LOAD;
          state_next = WAIT;
        end
      end

      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // The drive index doubles as the {c_in, oper} ALU control.
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_c_in  = idx_reg[3];
  assign alu_oper  = idx_reg[2:0];
  assign busy      = busy_reg;
  assign res_valid = res_valid_reg;
  assign res_idx   = res_idx_reg;
  assign res_sum   = res_sum_reg;
  assign res_c_out = res_c_out_reg;
  assign done      = done_reg;
  assign signature = sig_reg;
`ifdef ALU_SWEEP_CHECK_EN
  assign mismatch  = mismatch_reg;
`endif

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Bench for alu_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driving stub ALUs,
// checked every cycle against a sweep-timeline model plus directed literal expectations.
module tb_alu_sweep_ctrl;

  localparam int S1 = 1;
  localparam int S3 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [7:0]  a_in = 8'h00;
  logic [7:0]  b_in = 8'h00;
  logic [15:0] exp_sig = 16'h0000;
  int          mode1 = 0;

  logic [7:0]  a1, b1, sum1, rsum1, a3, b3, sum3, rsum3;
  logic        cin1, cout1, busy1, rv1, rcout1, done1, mis1;
  logic        cin3, cout3, busy3, rv3, rcout3, done3, mis3;
  logic [2:0]  oper1, oper3;
  logic [3:0]  ridx1, ridx3;
  logic [15:0] sig1, sig3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stub ALU: mode 0 adds, mode 1 returns constant 1, mode 2 echoes the index.
  function automatic logic [8:0] stub_fn(input int mode, input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] k);
    case (mode)
      0:       return 9'(a) + 9'(b) + 9'(k);
      1:       return 9'h001;
      default: return {~k[0], 4'h0, k};
    endcase
  endfunction

  logic [8:0] stub1, stub3;
  logic [3:0] d1, d2, d3;

  always_comb stub1 = stub_fn(mode1, a1, b1, {cin1, oper1});
  assign {cout1, sum1} = stub1;

  // SETTLE=3 stub only produces a valid answer once its inputs have been stable for 3 edges.
  always @(posedge clk) begin
    d1 <= {cin3, oper3};
    d2 <= d1;
    d3 <= d2;
  end
  always_comb begin
    if ({cin3, oper3} == d1 && d1 == d2 && d2 == d3) stub3 = stub_fn(2, a3, b3, {cin3, oper3});
    else stub3 = 9'h1EE;
  end
  assign {cout3, sum3} = stub3;

  alu_sweep_ctrl #(.SETTLE(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a_in), .b_in(b_in),
    .alu_a(a1), .alu_b(b1), .alu_c_in(cin1), .alu_oper(oper1),
    .alu_sum(sum1), .alu_c_out(cout1), .busy(busy1), .res_valid(rv1),
    .res_idx(ridx1), .res_sum(rsum1), .res_c_out(rcout1), .done(done1),
`ifdef ALU_SWEEP_CHECK_EN
    .exp_sig(exp_sig), .mismatch(mis1),
`endif
    .signature(sig1)
  );

  alu_sweep_ctrl #(.SETTLE(S3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_in(a_in), .b_in(b_in),
    .alu_a(a3), .alu_b(b3), .alu_c_in(cin3), .alu_oper(oper3),
    .alu_sum(sum3), .alu_c_out(cout3), .busy(busy3), .res_valid(rv3),
    .res_idx(ridx3), .res_sum(rsum3), .res_c_out(rcout3), .done(done3),
`ifdef ALU_SWEEP_CHECK_EN
    .exp_sig(exp_sig), .mismatch(mis3),
`endif
    .signature(sig3)
  );

`ifndef ALU_SWEEP_CHECK_EN
  assign mis1 = 1'b0;
  assign mis3 = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: a sweep is a timeline of 16*P+1 busy cycles ----------------
  int          m_n [2];
  bit          m_act [2];
  int          m_mode [2];
  logic        e_busy [2], e_rv [2], e_cout [2], e_done [2], e_mis [2];
  logic [3:0]  e_idx [2], e_drv [2];
  logic [7:0]  e_sum [2], e_a [2], e_b [2];
  logic [15:0] e_sig [2];

  function automatic int per(input int i);
    return (i == 0) ? S1 + 1 : S3 + 1;
  endfunction

  function automatic logic [15:0] sig_of(input int mode, input logic [7:0] a, input logic [7:0] b,
                                         input int k);
    logic [15:0] s = 16'h0000;
    for (int j = 0; j < k; j++) s = {s[14:0], s[15]} ^ {7'b0, stub_fn(mode, a, b, 4'(j))};
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; m_act[i] = 0; m_mode[i] = 0;
      e_busy[i] = 0; e_rv[i] = 0; e_cout[i] = 0; e_done[i] = 0; e_mis[i] = 0;
      e_idx[i] = 0; e_drv[i] = 0; e_sum[i] = 0; e_a[i] = 0; e_b[i] = 0; e_sig[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input logic st, input logic [15:0] es, input int mode);
    int k;
    e_rv[i] = 0;
    e_done[i] = 0;
    if (m_act[i]) begin
      m_n[i]++;
      if (m_n[i] > 16 * per(i)) m_act[i] = 0;
    end else if (st) begin
      m_act[i] = 1; m_n[i] = 0; m_mode[i] = mode;
      e_a[i] = a_in; e_b[i] = b_in; e_mis[i] = 0;
    end
    e_busy[i] = m_act[i];
    if (m_act[i]) begin
      k = m_n[i] / per(i);
      e_drv[i] = 4'((k > 15) ? 15 : k);
      e_sig[i] = sig_of(m_mode[i], e_a[i], e_b[i], (k > 16) ? 16 : k);
      if (m_n[i] > 0 && m_n[i] % per(i) == 0) begin
        e_rv[i] = 1;
        e_idx[i] = 4'(k - 1);
        {e_cout[i], e_sum[i]} = stub_fn(m_mode[i], e_a[i], e_b[i], 4'(k - 1));
      end
      if (m_n[i] == 16 * per(i)) begin
        e_done[i] = 1;
        e_mis[i] = (e_sig[i] != es);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        model_edge(0, start1, exp_sig, mode1);
        model_edge(1, start3, exp_sig, 2);
      end
    end
  end

  task automatic cmp(input int i, input logic bz, input logic rv, input logic [3:0] ri,
                     input logic [7:0] rs, input logic rc, input logic dn, input logic [15:0] sg,
                     input logic [7:0] aa, input logic [7:0] bb, input logic [3:0] dv,
                     input logic ms);
    chk($sformatf("busy%0d", i), 32'(bz), 32'(e_busy[i]));
    chk($sformatf("res_valid%0d", i), 32'(rv), 32'(e_rv[i]));
    chk($sformatf("res_idx%0d", i), 32'(ri), 32'(e_idx[i]));
    chk($sformatf("res_sum%0d", i), 32'(rs), 32'(e_sum[i]));
    chk($sformatf("res_c_out%0d", i), 32'(rc), 32'(e_cout[i]));
    chk($sformatf("done%0d", i), 32'(dn), 32'(e_done[i]));
    chk($sformatf("signature%0d", i), 32'(sg), 32'(e_sig[i]));
    chk($sformatf("alu_a%0d", i), 32'(aa), 32'(e_a[i]));
    chk($sformatf("alu_b%0d", i), 32'(bb), 32'(e_b[i]));
    chk($sformatf("drive%0d", i), 32'(dv), 32'(e_drv[i]));
`ifdef ALU_SWEEP_CHECK_EN
    chk($sformatf("mismatch%0d", i), 32'(ms), 32'(e_mis[i]));
`else
    if (ms !== 1'b0) chk($sformatf("mismatch_tie%0d", i), 32'(ms), 32'(0));
`endif
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp(0, busy1, rv1, ridx1, rsum1, rcout1, done1, sig1, a1, b1, {cin1, oper1}, mis1);
      cmp(1, busy3, rv3, ridx3, rsum3, rcout3, done3, sig3, a3, b3, {cin3, oper3}, mis3);
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic get_busy(input int i);
    return (i == 0) ? busy1 : busy3;
  endfunction

  task automatic set_start(input int i, input logic v);
    if (i == 0) start1 = v;
    else start3 = v;
  endtask

  // Runs one sweep; c counts negedges after the start edge (c=1 is the first busy cycle).
  task automatic sweep(input int i, input int pulse_at, input int rst_at,
                       output int bc, output int da, output int np);
    bc = 0; da = 0; np = 0;
    @(negedge clk);
    set_start(i, 1'b1);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      set_start(i, c == pulse_at);
      if (c == 3) begin a_in = ~a_in; b_in = ~b_in; end
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy1), 32'(0));
        chk("rst_done", 32'(done1), 32'(0));
        chk("rst_res_valid", 32'(rv1), 32'(0));
        chk("rst_alu_a", 32'(a1), 32'(0));
        chk("rst_drive", 32'({cin1, oper1}), 32'(0));
        chk("rst_signature", 32'(sig1), 32'(0));
        return;
      end
      if (get_busy(i)) bc++;
      if ((i == 0) ? rv1 : rv3) begin
        np++;
        if (i == 0) $display("dut0 result idx=%0d sum=%02h c_out=%0b sig=%04h", ridx1, rsum1, rcout1, sig1);
        else        $display("dut1 result idx=%0d sum=%02h c_out=%0b sig=%04h", ridx3, rsum3, rcout3, sig3);
      end
      if ((i == 0) ? done1 : done3) da = c;
      if (!get_busy(i)) return;
    end
    chk("sweep_timeout", 32'(get_busy(i)), 32'(0));
  endtask

  initial begin
    int bc, da, np, nd, d2;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset: nothing moves for 100 cycles.
    np = 0;
    repeat (100) begin
      @(negedge clk);
      if (rv1 || rv3 || busy1 || busy3) np++;
    end
    chk("idle_activity", 32'(np), 32'(0));
    chk("idle_signature", 32'(sig1), 32'(0));

    // Sweep order and timing, SETTLE=1.
    a_in = 8'h0F; b_in = 8'hF3; mode1 = 0;
    sweep(0, 0, 0, bc, da, np);
    chk("s1_busy_cycles", 32'(bc), 32'(33));
    chk("s1_done_cycle", 32'(da), 32'(33));
    chk("s1_pulses", 32'(np), 32'(16));
    chk("s1_alu_a_held", 32'(a1), 32'(8'h0F));
    chk("s1_alu_b_held", 32'(b1), 32'(8'hF3));

    // Constant-one ALU gives an all-ones signature.
    a_in = 8'h55; b_in = 8'hAA; mode1 = 1; exp_sig = 16'hFFFF;
    sweep(0, 0, 0, bc, da, np);
    chk("sig_ones", 32'(sig1), 32'(16'hFFFF));
    chk("sig_last_sum", 32'(rsum1), 32'(8'h01));
    chk("sig_pulses", 32'(np), 32'(16));
`ifdef ALU_SWEEP_CHECK_EN
    chk("mismatch_match", 32'(mis1), 32'(0));
    exp_sig = 16'hFFFE;
    sweep(0, 0, 0, bc, da, np);
    chk("mismatch_set", 32'(mis1), 32'(1));
    repeat (10) @(negedge clk);
    chk("mismatch_hold", 32'(mis1), 32'(1));
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("mismatch_clear", 32'(mis1), 32'(0));
    for (int c = 0; c < 100 && busy1; c++) @(negedge clk);
    chk("mismatch_sweep_end", 32'(busy1), 32'(0));
`endif

    // Settle timing, SETTLE=3 with a slow stub.
    a_in = 8'h12; b_in = 8'h34;
    sweep(1, 0, 0, bc, da, np);
    chk("s3_busy_cycles", 32'(bc), 32'(65));
    chk("s3_done_cycle", 32'(da), 32'(65));
    chk("s3_pulses", 32'(np), 32'(16));

    // start held high across DONE relaunches immediately.
    a_in = 8'h80; b_in = 8'h80; mode1 = 0;
    nd = 0; d2 = 0;
    @(negedge clk);
    start1 = 1'b1;
    for (int c = 1; c <= 200 && nd < 2; c++) begin
      @(negedge clk);
      if (done1) begin nd++; if (nd == 2) d2 = c; end
    end
    start1 = 1'b0;
    chk("held_second_done", 32'(d2), 32'(67));
    for (int c = 0; c < 10 && busy1; c++) @(negedge clk);
    chk("held_stops", 32'(busy1), 32'(0));

    // start pulse mid-sweep is ignored.
    a_in = 8'h3C; b_in = 8'hC3;
    sweep(0, 11, 0, bc, da, np);
    chk("midstart_busy_cycles", 32'(bc), 32'(33));
    chk("midstart_pulses", 32'(np), 32'(16));

    // Reset at step 9 aborts without a done pulse; the next sweep is complete.
    sweep(0, 0, 19, bc, da, np);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1 || busy1) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'(0));
    a_in = 8'h7E; b_in = 8'h01;
    sweep(0, 0, 0, bc, da, np);
    chk("post_rst_busy_cycles", 32'(bc), 32'(33));
    chk("post_rst_pulses", 32'(np), 32'(16));
    chk("post_rst_alu_a", 32'(a1), 32'(8'h7E));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
